// File: rtl/demux_lane_deserializer.sv
// demux_lane_deserializer: per-lane bit-to-word assembly after the 1x4 demux.
// One holding word per lane, drained round-robin through a valid/ready port.
module demux_lane_deserializer #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              bit_vld,
  input  logic [1:0]        sel,
  input  logic              a,
  input  logic              b,
  input  logic              c,
  input  logic              d,
  input  logic              clr,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [WORD_W-1:0] out_data,
  output logic [1:0]        out_lane,
  output logic [3:0]        ovf,
  input  logic [3:0]        ovf_clr
);

  localparam int SW = WORD_W - 1;
  localparam int CW = (WORD_W > 2) ? $clog2(WORD_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORD_W - 1);

  logic [SW-1:0]     sreg_q [4];
  logic [SW-1:0]     sreg_d [4];
  logic [CW-1:0]     cnt_q  [4];
  logic [CW-1:0]     cnt_d  [4];
  logic [WORD_W-1:0] hold_q [4];
  logic [WORD_W-1:0] hold_d [4];
  logic [3:0]        hold_full_q, hold_full_d;
  logic [3:0]        ovf_q, ovf_d, ovf_set;
  logic              out_vld_q, out_vld_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic [1:0]        out_lane_q, out_lane_d;
  logic [1:0]        rr_q, rr_d;

  logic [1:0] lane;
  logic       bit_in;
  logic       load;
  logic       found;
  logic [1:0] win;
  logic [1:0] idx;
  logic [3:0] pop;

  // Map the demux select code to a lane index and pick that lane's bit.
  always_comb begin
    lane   = 2'd0;
    bit_in = a;
    unique case (sel)
      2'b00: begin lane = 2'd0; bit_in = a; end
      2'b10: begin lane = 2'd1; bit_in = b; end
      2'b01: begin lane = 2'd2; bit_in = c; end
      2'b11: begin lane = 2'd3; bit_in = d; end
    endcase
  end

  // Round-robin pick of a full holding reg and output register update.
  always_comb begin
    found      = 1'b0;
    win        = 2'd0;
    idx        = 2'd0;
    pop        = 4'b0;
    load       = !out_vld_q || out_rdy;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_lane_d = out_lane_q;
    rr_d       = rr_q;
    for (int k = 0; k < 4; k++) begin
      idx = rr_q + 2'(k);
      if (!found && hold_full_q[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    if (load) begin
      if (found) begin
        pop[win]   = 1'b1;
        out_vld_d  = 1'b1;
        out_data_d = hold_q[win];
        out_lane_d = win;
        rr_d       = win + 2'd1;
      end else begin
        out_vld_d  = 1'b0;
      end
    end
  end

  // Shift the decoded lane; hand finished words to holding or flag overflow.
  always_comb begin
    for (int l = 0; l < 4; l++) begin
      sreg_d[l] = sreg_q[l];
      cnt_d[l]  = cnt_q[l];
      hold_d[l] = hold_q[l];
    end
    hold_full_d = hold_full_q & ~pop;
    ovf_set     = 4'b0;
    if (bit_vld) begin
      sreg_d[lane] = SW'({sreg_q[lane], bit_in});
      if (cnt_q[lane] == LAST) begin
        cnt_d[lane] = '0;
        if (!hold_full_q[lane] || pop[lane]) begin
          hold_d[lane]      = {sreg_q[lane], bit_in};
          hold_full_d[lane] = 1'b1;
        end else begin
          ovf_set[lane] = 1'b1;
        end
      end else begin
        cnt_d[lane] = cnt_q[lane] + CW'(1);
      end
    end
  end

  // Sticky overflow: a new drop wins over a same-cycle clear.
  always_comb begin
    ovf_d = ovf_q & ~ovf_clr;
    if (!clr) ovf_d = ovf_d | ovf_set;
  end

  // State registers; clr flushes everything except the overflow flags.
  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      for (int l = 0; l < 4; l++) begin
        sreg_q[l] <= '0;
        cnt_q[l]  <= '0;
        hold_q[l] <= '0;
      end
      hold_full_q <= 4'b0;
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      out_lane_q  <= 2'd0;
      rr_q        <= 2'd0;
    end else begin
      for (int l = 0; l < 4; l++) begin
        sreg_q[l] <= sreg_d[l];
        cnt_q[l]  <= cnt_d[l];
        hold_q[l] <= hold_d[l];
      end
      hold_full_q <= hold_full_d;
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      out_lane_q  <= out_lane_d;
      rr_q        <= rr_d;
    end
  end

  // Overflow register, cleared only by reset or ovf_clr.
  always_ff @(posedge clk) begin
    if (!rstn) ovf_q <= 4'b0;
    else       ovf_q <= ovf_d;
  end

  assign out_vld  = out_vld_q;
  assign out_data = out_data_q;
  assign out_lane = out_lane_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_demux_lane_deserializer.sv
// tb_demux_lane_deserializer: directed vectors, scoreboard queue of
// expected {lane,word}; a negedge monitor pops on each transfer.
module tb_demux_lane_deserializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rstn;
  logic         bit_vld;
  logic [1:0]   sel;
  logic         a, b, c, d;
  logic         clr;
  logic         out_vld;
  logic         out_rdy;
  logic [W-1:0] out_data;
  logic [1:0]   out_lane;
  logic [3:0]   ovf;
  logic [3:0]   ovf_clr;

  int total = 0;
  int bad   = 0;

  logic [W+1:0] exp_q[$];

  demux_lane_deserializer #(.WORD_W(W)) dut (
    .clk(clk), .rstn(rstn), .bit_vld(bit_vld), .sel(sel),
    .a(a), .b(b), .c(c), .d(d), .clr(clr),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
    .out_lane(out_lane), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] sel_of(input int ln);
    case (ln)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b01;
      default: return 2'b11;
    endcase
  endfunction

  // Non-selected lanes carry the inverted bit so leakage shows up.
  task automatic send_bit(input int ln, input logic v);
    bit_vld = 1'b1;
    sel     = sel_of(ln);
    {a, b, c, d} = {4{~v}};
    case (ln)
      0:       a = v;
      1:       b = v;
      2:       c = v;
      default: d = v;
    endcase
    tick();
    bit_vld = 1'b0;
  endtask

  task automatic send_word(input int ln, input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) send_bit(ln, w[i]);
  endtask

  task automatic expect_word(input int ln, input logic [W-1:0] w);
    exp_q.push_back({2'(ln), w});
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    repeat (3) tick();
    chk("drain", exp_q.size(), 0);
  endtask

  // Monitor: every accepted output word must match the queue head.
  initial begin
    logic [W+1:0] e;
    forever begin
      @(negedge clk);
      if (rstn && out_vld && out_rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {out_lane, out_data}, 32'hFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("word_data", out_data, e[W-1:0]);
          chk("word_lane", out_lane, e[W+1:W]);
        end
      end
    end
  end

  initial begin
    logic [W-1:0] wb, wc;
    rstn = 1'b0; bit_vld = 1'b0; sel = 2'b00;
    {a, b, c, d} = 4'b0; clr = 1'b0;
    out_rdy = 1'b1; ovf_clr = 4'b0;
    repeat (3) tick();
    chk("rst_vld",  out_vld,  0);
    chk("rst_data", out_data, 0);
    chk("rst_lane", out_lane, 0);
    chk("rst_ovf",  ovf,      0);
    rstn = 1'b1;
    tick();

    // Single word on lane a, exact latency.
    expect_word(0, 8'hB2);
    send_word(0, 8'hB2);
    chk("t1_vld_n",  out_vld, 0);
    tick();
    chk("t1_vld_n1", out_vld, 1);
    chk("t1_data",   out_data, 8'hB2);
    chk("t1_lane",   out_lane, 0);
    tick();
    chk("t1_vld_n2", out_vld, 0);

    // Interleaved lanes b and c.
    wb = 8'hFF; wc = 8'h0F;
    expect_word(1, wb);
    expect_word(2, wc);
    for (int i = W - 1; i >= 0; i--) begin
      send_bit(1, wb[i]);
      send_bit(2, wc[i]);
    end
    drain();
    chk("t2_ovf", ovf, 0);

    // Backpressure and overflow on lane d.
    out_rdy = 1'b0;
    send_word(3, 8'hA5);
    tick();
    chk("t3_vld",  out_vld, 1);
    chk("t3_data", out_data, 8'hA5);
    send_word(3, 8'h5A);
    chk("t3_stable", out_data, 8'hA5);
    chk("t3_lane",   out_lane, 3);
    chk("t3_ovf0",   ovf, 0);
    send_word(3, 8'hC3);
    chk("t3_ovf",    ovf, 4'b1000);
    expect_word(3, 8'hA5);
    expect_word(3, 8'h5A);
    out_rdy = 1'b1;
    drain();

    // All four lanes on one schedule.
    wb = 8'h11;
    for (int ln = 0; ln < 4; ln++) expect_word(ln, W'(8'h11 * (ln + 1)));
    for (int i = W - 1; i >= 0; i--)
      for (int ln = 0; ln < 4; ln++) begin
        wc = W'(8'h11 * (ln + 1));
        send_bit(ln, wc[i]);
      end
    drain();

    // Pointer resumes after lane a: b,c,d then the second a word.
    out_rdy = 1'b0;
    for (int i = W - 1; i >= 0; i--)
      for (int ln = 0; ln < 4; ln++) begin
        wc = W'(8'h55 + 8'h11 * ln);
        send_bit(ln, wc[i]);
      end
    send_word(0, 8'h99);
    tick();
    chk("t4_hold_lane", out_lane, 0);
    chk("t4_hold_data", out_data, 8'h55);
    expect_word(0, 8'h55);
    expect_word(1, 8'h66);
    expect_word(2, 8'h77);
    expect_word(3, 8'h88);
    expect_word(0, 8'h99);
    out_rdy = 1'b1;
    drain();
    chk("t4_ovf", ovf, 4'b1000);

    // clr drops a partial word but keeps ovf.
    for (int i = 0; i < 5; i++) send_bit(0, 1'b1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t5_ovf_kept", ovf, 4'b1000);
    expect_word(0, 8'h3C);
    send_word(0, 8'h3C);
    drain();

    // Write-1-to-clear.
    ovf_clr = 4'b1111;
    tick();
    ovf_clr = 4'b0;
    chk("t6_ovf_clr", ovf, 0);

    // Reset while a word waits on the output.
    out_rdy = 1'b0;
    send_word(1, 8'h01);
    send_word(1, 8'h02);
    send_word(1, 8'h03);
    chk("t7_ovf", ovf, 4'b0010);
    chk("t7_vld", out_vld, 1);
    rstn = 1'b0;
    tick();
    chk("t7_rst_vld", out_vld, 0);
    chk("t7_rst_ovf", ovf, 0);
    rstn = 1'b1;
    out_rdy = 1'b1;
    repeat (3) tick();
    chk("t7_no_stale", out_vld, 0);
    expect_word(2, 8'hAB);
    send_word(2, 8'hAB);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
